// File: rtl/lcd_serial_tx.sv
// Serial word writer for the LCD 3/4-wire port (CSB/SCL/SI/RS), MSB- or LSB-first, with burst CSB hold.
// Latency: (2*DATA_W+1)*CLK_DIV cycles from the accepting edge to done/ready; next start accepted the same cycle ready rises.
// Backpressure: ready=0 while a word is in flight; start is ignored unless ready=1.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start/data_in/rs_in/last   word request, latched when accepted (start & ready)
//   ready, done         can accept / one-cycle end-of-word pulse
//   csb, scl, si, rs    LCD pins; scl idles high, LCD samples si on scl rising edge
module lcd_serial_tx #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 20000,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rs_in,
    input  logic              last,
    output logic              ready,
    output logic              done,
    output logic              csb,
    output logic              scl,
    output logic              si,
    output logic              rs
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4,
        BURST = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ph_q, ph_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                csb_q, csb_d;
    logic                scl_q, scl_d;
    logic                si_q, si_d;
    logic                rs_q, rs_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                phase_end;

    // Bit select by index (word stays intact for the whole transfer).
    function automatic logic pick(input logic [DATA_W-1:0] w, input logic [BW-1:0] idx);
        if (MSB_FIRST != 0) begin
            return w[BIT_LAST - idx];
        end else begin
            return w[idx];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            csb_q   <= 1'b1;
            scl_q   <= 1'b1;
            si_q    <= 1'b0;
            rs_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            last_q  <= last_d;
            csb_q   <= csb_d;
            scl_q   <= scl_d;
            si_q    <= si_d;
            rs_q    <= rs_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        data_d    = data_q;
        last_d    = last_q;
        csb_d     = csb_q;
        scl_d     = scl_q;
        si_d      = si_q;
        rs_d      = rs_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        phase_end = (ph_q == PH_LAST);

        // Every timed phase lasts exactly CLK_DIV cycles.
        if (state_q inside {SETUP, LOW, HIGH, HOLD}) begin
            ph_d = phase_end ? '0 : ph_q + PW'(1);
        end

        case (state_q)
            IDLE, BURST: begin
                if (start) begin
                    data_d  = data_in;
                    rs_d    = rs_in;
                    last_d  = last;
                    csb_d   = 1'b0;
                    si_d    = pick(data_in, '0);
                    ready_d = 1'b0;
                    bit_d   = '0;
                    ph_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    scl_d   = 1'b0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    scl_d = 1'b1;
                    // The high half of the final bit doubles as the hold phase.
                    state_d = (bit_q == BIT_LAST) ? HOLD : HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    scl_d   = 1'b0;
                    si_d    = pick(data_q, bit_q + BW'(1));
                    bit_d   = bit_q + BW'(1);
                    state_d = LOW;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    if (last_q) begin
                        csb_d   = 1'b1;
                        si_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign csb   = csb_q;
    assign scl   = scl_q;
    assign si    = si_q;
    assign rs    = rs_q;

endmodule
